// File: rtl/iomem_arbiter.sv
// iomem_arbiter: round-robin two-master arbiter onto one iomem slave port, with a hung-access timeout
module iomem_arbiter #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                m0_valid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic                m0_ready_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_valid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic                m1_ready_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_valid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic                s_ready_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic [1:0]          grant_o,
    output logic                timeout_err_o
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        r_state, w_next;
    logic          r_win, r_rr;
    logic [CW-1:0] r_cnt;
    logic          w_req, w_pick, w_timeout, w_done;
    logic [DATA_W-1:0] w_rdata;

    assign w_req     = m0_valid_i | m1_valid_i;
    assign w_pick    = (m0_valid_i & m1_valid_i) ? r_rr : m1_valid_i;
    // s_ready_i on the last allowed cycle still counts as a good completion
    assign w_timeout = (TIMEOUT_CYCLES > 0) && r_state == ACCESS && !s_ready_i && r_cnt == CNT_LAST;
    assign w_done    = r_state == ACCESS && (s_ready_i || w_timeout);
    assign w_rdata   = s_ready_i ? s_rdata_i : ERR_RDATA;

    always_ff @(posedge clk_i)
        r_state <= !rst_n ? IDLE : w_next;

    always_comb
        w_next = r_state == IDLE   ? (w_req ? ACCESS : IDLE) :
                 r_state == ACCESS ? (w_done ? RESP : ACCESS) : IDLE;

    always_comb begin
        s_valid_o  = r_state == ACCESS;
        grant_o    = r_state == ACCESS ? {r_win, !r_win} : 2'b00;
        m0_ready_o = r_state == RESP && !r_win;
        m1_ready_o = r_state == RESP && r_win;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_win         <= 1'b0;
            r_rr          <= 1'b0;
            r_cnt         <= '0;
            s_addr_o      <= '0;
            s_wdata_o     <= '0;
            s_wstrb_o     <= '0;
            m0_rdata_o    <= '0;
            m1_rdata_o    <= '0;
            timeout_err_o <= 1'b0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_win     <= w_pick;
                s_addr_o  <= w_pick ? m1_addr_i  : m0_addr_i;
                s_wdata_o <= w_pick ? m1_wdata_i : m0_wdata_i;
                s_wstrb_o <= w_pick ? m1_wstrb_i : m0_wstrb_i;
            end
            if (r_state == ACCESS && TIMEOUT_CYCLES > 0)
                r_cnt <= r_cnt + 1'b1;
            if (w_done && !r_win)
                m0_rdata_o <= w_rdata;
            if (w_done && r_win)
                m1_rdata_o <= w_rdata;
            if (w_timeout)
                timeout_err_o <= 1'b1;
            if (r_state == RESP) begin
                r_rr  <= !r_win;
                r_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_iomem_arbiter.sv
// tb_iomem_arbiter: scoreboard bench for iomem_arbiter with a transaction-level arbitration model
module tb_iomem_arbiter;
    localparam int TO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    typedef struct {
        int          m;
        logic [31:0] rd;
        int          len;
        logic        err;
    } exp_t;

    logic        clk_i, rst_n;
    logic        m0_valid_i, m1_valid_i, m0_ready_o, m1_ready_o;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i, m0_rdata_o, m1_rdata_o;
    logic [3:0]  m0_wstrb_i, m1_wstrb_i;
    logic        s_valid_o, s_ready_i, timeout_err_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [3:0]  s_wstrb_o;
    logic [1:0]  grant_o;

    int   total = 0, bad = 0;
    exp_t sq[$];
    int   force_k = 0;
    int   s_win, s_k, s_cyc, scnt;
    logic [31:0] s_rd;
    logic [67:0] s_req;
    logic [31:0] lastrd [2];
    bit   in_acc, pv0, pv1, rr_m, err_m, to_m;
    exp_t e;

    iomem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
        .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o),
        .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
        .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o),
        .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
        .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i),
        .grant_o(grant_o), .timeout_err_o(timeout_err_o)
    );

    initial clk_i = 0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Slave model and arbitration reference: predicts the owner of each new access from the
    // requests pending at the arbitration edge and the last served master.
    always @(negedge clk_i) begin
        if (!rst_n) begin
            sq.delete();
            rr_m = 0; err_m = 0; in_acc = 0;
            s_ready_i = 0; s_rdata_i = 0;
        end else begin
            s_ready_i = 0;
            if (s_valid_o && !in_acc) begin
                in_acc = 1; s_cyc = 0;
                chk("arb_had_request", 128'(pv0 | pv1), 1);
                s_win = (pv0 && pv1) ? int'(rr_m) : int'(pv1);
                s_req = s_win != 0 ? {m1_addr_i, m1_wdata_i, m1_wstrb_i} : {m0_addr_i, m0_wdata_i, m0_wstrb_i};
                s_k   = force_k > 0 ? force_k : int'($urandom_range(1, 10));
                s_rd  = $urandom;
                to_m  = s_k > TO;
                err_m = err_m | to_m;
                sq.push_back('{s_win, to_m ? ERR : s_rd, to_m ? TO : s_k, err_m});
                rr_m  = s_win == 0;
            end
            if (s_valid_o) begin
                s_cyc++;
                chk("grant", 128'(grant_o), s_win != 0 ? 2 : 1);
                chk("s_req", 128'({s_addr_o, s_wdata_o, s_wstrb_o}), 128'(s_req));
                if (s_cyc == s_k) begin
                    s_ready_i = 1;
                    s_rdata_i = s_rd;
                end
            end else begin
                in_acc    = 0;
                s_ready_i = $urandom_range(0, 3) == 0;
                s_rdata_i = $urandom;
            end
            pv0 = m0_valid_i;
            pv1 = m1_valid_i;
        end
    end

    // Monitor: every master completion is matched against the head of the scoreboard
    always @(negedge clk_i) begin
        if (!rst_n) begin
            scnt = 0; lastrd[0] = 0; lastrd[1] = 0;
        end else begin
            if (s_valid_o) scnt++;
            if (m0_ready_o || m1_ready_o) begin
                chk("ready_expected", 128'(sq.size() > 0), 1);
                if (sq.size() > 0) begin
                    e = sq.pop_front();
                    chk("ready_sel", 128'({m1_ready_o, m0_ready_o}), e.m != 0 ? 2 : 1);
                    chk("rdata", 128'(e.m != 0 ? m1_rdata_o : m0_rdata_o), 128'(e.rd));
                    chk("other_rdata_held", 128'(e.m != 0 ? m0_rdata_o : m1_rdata_o), 128'(lastrd[1 - e.m]));
                    chk("s_valid_len", 128'(scnt), 128'(e.len));
                    chk("timeout_err", 128'(timeout_err_o), 128'(e.err));
                    lastrd[e.m] = e.rd;
                end
                scnt = 0;
            end
        end
    end

    task automatic req(input int m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int lat);
        int n = 0;
        logic rdy;
        if (m == 0) begin m0_addr_i = a; m0_wdata_i = wd; m0_wstrb_i = ws; m0_valid_i = 1; end
        else        begin m1_addr_i = a; m1_wdata_i = wd; m1_wstrb_i = ws; m1_valid_i = 1; end
        do begin
            @(posedge clk_i); #1; n++;
            rdy = m == 0 ? m0_ready_o : m1_ready_o;
        end while (!rdy && n < 200);
        if (!rdy) chk("ready_wait_bound", 128'(n), 0);
        else if (lat > 0) chk("latency", 128'(n), 128'(lat));
        if (m == 0) m0_valid_i = 0; else m1_valid_i = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic master(input int m, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
            req(m, $urandom, $urandom, $urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 15)) : 4'h0, 0);
        end
    endtask

    task automatic chk_reset_outs();
        chk("reset_s", 128'({s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o, grant_o, timeout_err_o}), 0);
        chk("reset_m", 128'({m0_ready_o, m1_ready_o, m0_rdata_o, m1_rdata_o}), 0);
    endtask

    initial begin
        int n;
        rst_n = 0;
        {m0_valid_i, m0_addr_i, m0_wdata_i, m0_wstrb_i} = '0;
        {m1_valid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i} = '0;
        repeat (3) @(posedge clk_i);
        #1 chk_reset_outs();
        rst_n = 1;
        force_k = 5;  req(0, 32'h4000_0010, 32'h0, 4'h0, 6);
        force_k = 3;  req(1, 32'h4000_0004, 32'hCAFE_F00D, 4'b0011, 4);
        force_k = 2;
        repeat (3) fork
            req(0, $urandom, $urandom, 4'h0, 0);
            req(1, $urandom, $urandom, 4'hF, 0);
        join
        force_k = 1;  req(0, 32'h10, 32'h0, 4'h0, 2); req(1, 32'h20, 32'h5, 4'h1, 2);
        force_k = 8;  req(0, 32'h4000_0080, 32'h0, 4'h0, 9);
        chk("boundary_no_err", 128'(timeout_err_o), 0);
        force_k = 12; req(0, 32'h4000_0084, 32'h0, 4'h0, TO + 1);
        force_k = 3;  req(1, 32'h4000_0088, 32'h0, 4'h0, 4);
        chk("err_sticky", 128'(timeout_err_o), 1);
        force_k = 20;
        m0_addr_i = 32'h4000_0100; m0_wstrb_i = 0; m0_valid_i = 1;
        n = 0;
        do begin @(posedge clk_i); #1; n++; end while (!s_valid_o && n < 50);
        chk("rst_access_started", 128'(s_valid_o), 1);
        repeat (2) begin @(posedge clk_i); #1; end
        rst_n = 0; m0_valid_i = 0;
        @(posedge clk_i); #1;
        chk_reset_outs();
        rst_n = 1;
        repeat (4) begin @(posedge clk_i); #1; end
        force_k = 2;
        fork
            req(0, 32'h4000_0200, 32'h0, 4'h0, 3);
            req(1, 32'h4000_0204, 32'h0, 4'h0, 0);
        join
        force_k = 0;
        fork
            master(0, 30);
            master(1, 30);
        join
        repeat (5) begin @(posedge clk_i); #1; end
        chk("scoreboard_drained", 128'(sq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
